dm_cache_stage: RTL
===================

Name: dm_cache_stage

Overview:
- Data-memory stage directly downstream of the AG→DM pipeline register.
- Consumes the registered load and store requests and serves loads from a direct-mapped, write-through, no-write-allocate data cache.
- Misses and all stores go to a single-ported backing memory over a req/ack handshake.
- Returns load data tagged with its instruction number to writeback, and stalls upstream while a memory transaction is outstanding.

Parameters:
- IDX_W, 4, index bits; cache holds 2^IDX_W one-word lines.
- MEM_TO, 255, max cycles waiting for mem_ack before the transaction is flagged as a bus error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- ld_req  in  1  load request valid this cycle
- LdAddr_DM  in  32  load byte address
- LdInstrNO_DM  in  32  load instruction number
- LdInstr_DM  in  32  load instruction word
- WE_DM  in  1  store request; sampled as a level at the rising edge, so the upstream register holds it for the full cycle
- StrAddr_DM  in  32  store byte address
- WriteData_DM  in  32  store data
- stall  out  1  upstream must hold all inputs unchanged while 1
- ld_valid  out  1  one-cycle pulse; load result valid
- ld_data  out  32  load result
- ld_instr_no  out  32  instruction number of the returned load
- ld_instr  out  32  instruction word of the returned load
- bus_err  out  1  sticky; set on mem_ack timeout, cleared only by rst
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=write, 0=read; stable while mem_req is high
- mem_addr  out  32  word-aligned address (bits[1:0]=0)
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Address split:
  - index = addr[IDX_W+1:2]
  - tag = addr[31:IDX_W+2]
  - addr[1:0] ignored
- Reset state:
  - All valid bits 0.
  - State IDLE.
  - Every output 0, including stall, mem_req and bus_err.
  - Reset mid-transaction aborts it immediately; mem_req drops asynchronously.
- A request is accepted at a rising edge when state=IDLE and (ld_req or WE_DM).
- FSM states: IDLE, WRITE, FILL, RESP.
- IDLE transitions:
  - Store accepted → WRITE.
  - Load miss with no store → FILL.
  - Load hit with no store → stay in IDLE; ld_valid=1 next cycle with the cached word (hit latency 1).
- Store accepted:
  - Latch address and data.
  - If the store hits, update the line in the same edge. A miss leaves the cache unchanged.
  - Go to WRITE.
- WRITE:
  - mem_req=1, mem_we=1.
  - On mem_ack: if a load miss is pending go to FILL, else IDLE.
- Load and store in the same cycle:
  - Store is applied first.
  - If the word addresses are equal, the load returns WriteData_DM with ld_valid on the next edge, no FILL, and the cache is not allocated.
  - Otherwise the load is looked up against pre-store contents. A hit is returned next cycle; a miss is latched and handled after WRITE.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = latched load address.
  - On mem_ack: write mem_rdata into the line (set valid, set tag), capture it as ld_data, go to RESP.
- RESP: ld_valid=1 for one cycle, then IDLE.
- stall = (state != IDLE). Miss latency = 1 + ack delay + 1.
- ld_instr_no and ld_instr always travel with the load they belong to. They are held after ld_valid drops; don't-care when ld_valid=0.
- Timeout: a counter counts cycles in WRITE or FILL.
  - On reaching MEM_TO: bus_err=1 and mem_req drops.
  - A FILL that times out returns ld_data=0 via RESP; the line is not filled.
  - A WRITE that times out proceeds as if acked.
- mem_ack outside WRITE/FILL is ignored.

Decomposition:
- Shared package dm_pkg:
  - FSM state enum (IDLE/WRITE/FILL/RESP)
  - Address-split helper functions (index/tag from IDX_W)
  - Default MEM_TO constant
- One natural sub-module: dm_cache_array, holding the tag/valid/data arrays. It has one combinational read port (index) and one write port (index, tag, data, we), plus a valid-clear on rst.

Test Plan:
- Cold load 0x100, ack after 3 cycles with 0xDEADBEEF → mem_req rd addr 0x100 for 3 cycles; ld_valid with 0xDEADBEEF and correct instr no; repeat load → ld_valid next cycle, no mem_req.
- Store 0x100←0x12345678 (hit), then load 0x100 → mem write 0x100/0x12345678; stall until ack; load hits with 0x12345678.
- Store 0x200←0xAA and load 0x200 in the same cycle → ld_valid next edge with 0xAA; then mem write; a later load of 0x200 misses (no allocate).
- Store 0x300←0x5 with load 0x140 miss in the same cycle → WRITE 0x300 first, then FILL 0x140; stall continuous throughout; single ld_valid.
- Alias check: load 0x040 then 0x080 with IDX_W=4 → second load misses, refills, and evicts; load 0x040 misses again.
- Assert rst during FILL, and separately hold mem_ack low for 256 cycles → rst drops mem_req immediately and clears valids; timeout sets bus_err and returns ld_data=0.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory stage.
//   - dm_state_e   : stage FSM states (IDLE / WRITE / FILL / RESP)
//   - DEF_MEM_TO   : default number of cycles to wait for mem_ack
//   - addr_index() : line index of a byte address, addr[idx_w+1:2]
//   - addr_tag()   : tag of a byte address, addr[31:idx_w+2]
package dm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_FILL  = 2'd2,
      ST_RESP  = 2'd3
   } dm_state_e;

   localparam int DEF_MEM_TO = 255;

   // Results are 32 bits wide; callers cast down to IDX_W / tag width.
   function automatic logic [31:0] addr_index(input logic [31:0] addr, input int idx_w);
      return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int idx_w);
      return addr >> (idx_w + 2);
   endfunction

endpackage

// File: rtl/dm_cache_array.sv
// dm_cache_array: tag/valid/data storage for a direct-mapped cache of
// 2^IDX_W one-word lines.
//   clk, rst   : clock, asynchronous active-high reset (clears valid bits only)
//   rd_*       : combinational read port addressed by rd_idx
//   wr_*       : write port; with wr_if_hit=1 the write only lands when the
//                addressed line is valid and already holds wr_tag (store update)
module dm_cache_array #(
   parameter int IDX_W = 4,
   parameter int TAG_W = 30 - IDX_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic             wr_if_hit,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [31:0]      wr_data
);

   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];
   logic             wr_do;

   // A conditional write compares against the line's current contents, so a
   // store and a load lookup can share the cycle with a single read port.
   assign wr_do = wr_en && (!wr_if_hit || (valid_q[wr_idx] && (tag_mem[wr_idx] == wr_tag)));

   always_comb begin
      valid_d = valid_q;
      if (wr_do) valid_d[wr_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      if (wr_do) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dm_cache_stage.sv
// dm_cache_stage: data-memory stage with a direct-mapped, write-through,
// no-write-allocate cache in front of a single-ported backing memory.
//   clk, rst                  : clock, asynchronous active-high reset
//   ld_req/LdAddr_DM/...      : registered load request from AG->DM
//   WE_DM/StrAddr_DM/...      : registered store request from AG->DM
//   stall                     : upstream holds inputs while 1
//   ld_valid/ld_data/...      : load result to writeback (one-cycle pulse)
//   bus_err                   : sticky mem_ack timeout flag
//   mem_req/we/addr/wdata     : backing memory request, held until mem_ack
//   mem_rdata/mem_ack         : backing memory response
module dm_cache_stage
   import dm_pkg::*;
#(
   parameter int IDX_W  = 4,
   parameter int MEM_TO = DEF_MEM_TO
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_req,
   input  logic [31:0] LdAddr_DM,
   input  logic [31:0] LdInstrNO_DM,
   input  logic [31:0] LdInstr_DM,
   input  logic        WE_DM,
   input  logic [31:0] StrAddr_DM,
   input  logic [31:0] WriteData_DM,
   output logic        stall,
   output logic        ld_valid,
   output logic [31:0] ld_data,
   output logic [31:0] ld_instr_no,
   output logic [31:0] ld_instr,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int TAG_W = 30 - IDX_W;
   localparam int CNT_W = $clog2(MEM_TO + 1);

   dm_state_e   state_q, state_d;
   logic [31:2] ld_addr_q, ld_addr_d;
   logic [31:2] st_addr_q, st_addr_d;
   logic [31:0] st_data_q, st_data_d;
   logic        pend_ld_q, pend_ld_d;
   logic        ld_valid_q, ld_valid_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic [31:0] ld_instr_no_q, ld_instr_no_d;
   logic [31:0] ld_instr_q, ld_instr_d;
   logic        bus_err_q, bus_err_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_data;
   logic             wr_en, wr_if_hit;
   logic [IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0] wr_tag;
   logic [31:0]      wr_data;

   logic [IDX_W-1:0] ld_idx, st_idx, fill_idx;
   logic [TAG_W-1:0] ld_tag, st_tag, fill_tag;
   logic             ld_hit, same_word, timeout;

   assign ld_idx    = IDX_W'(addr_index(LdAddr_DM, IDX_W));
   assign ld_tag    = TAG_W'(addr_tag(LdAddr_DM, IDX_W));
   assign st_idx    = IDX_W'(addr_index(StrAddr_DM, IDX_W));
   assign st_tag    = TAG_W'(addr_tag(StrAddr_DM, IDX_W));
   assign fill_idx  = IDX_W'(addr_index({ld_addr_q, 2'b00}, IDX_W));
   assign fill_tag  = TAG_W'(addr_tag({ld_addr_q, 2'b00}, IDX_W));
   assign ld_hit    = rd_valid && (rd_tag == ld_tag);
   assign same_word = (LdAddr_DM[31:2] == StrAddr_DM[31:2]);
   // Fires on the MEM_TO-th cycle of a memory transaction without an ack.
   assign timeout   = (to_cnt_q == CNT_W'(MEM_TO - 1));

   dm_cache_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (ld_idx),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_if_hit (wr_if_hit),
      .wr_idx    (wr_idx),
      .wr_tag    (wr_tag),
      .wr_data   (wr_data)
   );

   always_comb begin
      state_d       = state_q;
      ld_addr_d     = ld_addr_q;
      st_addr_d     = st_addr_q;
      st_data_d     = st_data_q;
      pend_ld_d     = pend_ld_q;
      ld_valid_d    = 1'b0;
      ld_data_d     = ld_data_q;
      ld_instr_no_d = ld_instr_no_q;
      ld_instr_d    = ld_instr_q;
      bus_err_d     = bus_err_q;
      to_cnt_d      = to_cnt_q;
      wr_en         = 1'b0;
      wr_if_hit     = 1'b0;
      wr_idx        = ld_idx;
      wr_tag        = ld_tag;
      wr_data       = WriteData_DM;

      case (state_q)
         ST_IDLE: begin
            to_cnt_d = '0;
            if (WE_DM) begin
               // Write-through: update only a line that already holds the word.
               st_addr_d = StrAddr_DM[31:2];
               st_data_d = WriteData_DM;
               wr_en     = 1'b1;
               wr_if_hit = 1'b1;
               wr_idx    = st_idx;
               wr_tag    = st_tag;
               pend_ld_d = 1'b0;
               state_d   = ST_WRITE;
            end
            if (ld_req) begin
               ld_addr_d     = LdAddr_DM[31:2];
               ld_instr_no_d = LdInstrNO_DM;
               ld_instr_d    = LdInstr_DM;
               if (WE_DM && same_word) begin
                  // Forward the store data; the store never allocates.
                  ld_valid_d = 1'b1;
                  ld_data_d  = WriteData_DM;
               end else if (ld_hit) begin
                  // Lookup sees pre-store contents.
                  ld_valid_d = 1'b1;
                  ld_data_d  = rd_data;
               end else if (WE_DM) begin
                  pend_ld_d = 1'b1;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end
         ST_WRITE: begin
            if (mem_ack || timeout) begin
               bus_err_d = bus_err_q | ~mem_ack;
               to_cnt_d  = '0;
               pend_ld_d = 1'b0;
               state_d   = pend_ld_q ? ST_FILL : ST_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + CNT_W'(1);
            end
         end
         ST_FILL: begin
            if (mem_ack) begin
               wr_en      = 1'b1;
               wr_idx     = fill_idx;
               wr_tag     = fill_tag;
               wr_data    = mem_rdata;
               ld_data_d  = mem_rdata;
               ld_valid_d = 1'b1;
               to_cnt_d   = '0;
               state_d    = ST_RESP;
            end else if (timeout) begin
               bus_err_d  = 1'b1;
               ld_data_d  = '0;
               ld_valid_d = 1'b1;
               to_cnt_d   = '0;
               state_d    = ST_RESP;
            end else begin
               to_cnt_d = to_cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         ld_addr_q     <= '0;
         st_addr_q     <= '0;
         st_data_q     <= '0;
         pend_ld_q     <= 1'b0;
         ld_valid_q    <= 1'b0;
         ld_data_q     <= '0;
         ld_instr_no_q <= '0;
         ld_instr_q    <= '0;
         bus_err_q     <= 1'b0;
         to_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         ld_addr_q     <= ld_addr_d;
         st_addr_q     <= st_addr_d;
         st_data_q     <= st_data_d;
         pend_ld_q     <= pend_ld_d;
         ld_valid_q    <= ld_valid_d;
         ld_data_q     <= ld_data_d;
         ld_instr_no_q <= ld_instr_no_d;
         ld_instr_q    <= ld_instr_d;
         bus_err_q     <= bus_err_d;
         to_cnt_q      <= to_cnt_d;
      end
   end

   // Memory-side outputs decode straight from the state register so an
   // asynchronous reset drops mem_req immediately.
   assign stall       = (state_q != ST_IDLE);
   assign mem_req     = (state_q == ST_WRITE) || (state_q == ST_FILL);
   assign mem_we      = (state_q == ST_WRITE);
   assign mem_addr    = (state_q == ST_WRITE) ? {st_addr_q, 2'b00} :
                        (state_q == ST_FILL)  ? {ld_addr_q, 2'b00} : 32'h0;
   assign mem_wdata   = (state_q == ST_WRITE) ? st_data_q : 32'h0;
   assign ld_valid    = ld_valid_q;
   assign ld_data     = ld_data_q;
   assign ld_instr_no = ld_instr_no_q;
   assign ld_instr    = ld_instr_q;
   assign bus_err     = bus_err_q;

endmodule
